// File: rtl/async_mem_master.sv
// Synchronous request/ack to asynchronous SRAM/flash strobe cycle initiator.
// Programmable setup/pulse/hold timing with a resynchronised wait_n stretch.
module async_mem_master #(
    parameter int AW           = 24,
    parameter int DW           = 16,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 3,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW/8-1:0] sel,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata,
    output logic            ack,
    output logic            busy,
    output logic [AW-1:0]   mem_addr,
    output logic [DW/8-1:0] mem_be_n,
    output logic            mem_ce_n,
    output logic            mem_oe_n,
    output logic            mem_we_n,
    output logic [DW-1:0]   mem_d_out,
    output logic            mem_d_oe,
    input  logic [DW-1:0]   mem_d_in,
    input  logic            mem_wait_n
);

    localparam int BW = DW / 8;
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t          state, state_nx;
    logic [7:0]      cnt, cnt_nx;
    logic            xfer_we, xfer_we_nx;
    logic            wait_m, wait_s;
    logic [AW-1:0]   addr_nx;
    logic [BW-1:0]   be_n_nx;
    logic [DW-1:0]   d_out_nx, rdata_nx;
    logic            ce_n_nx, oe_n_nx, we_n_nx, d_oe_nx, ack_nx;

    // wait_n is asynchronous to clk; only wait_s may be used by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_m <= 1'b1;
            wait_s <= 1'b1;
        end else begin
            wait_m <= mem_wait_n;
            wait_s <= wait_m;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        xfer_we_nx = xfer_we;
        addr_nx    = mem_addr;
        be_n_nx    = mem_be_n;
        d_out_nx   = mem_d_out;
        rdata_nx   = rdata;
        ce_n_nx    = mem_ce_n;
        oe_n_nx    = mem_oe_n;
        we_n_nx    = mem_we_n;
        d_oe_nx    = mem_d_oe;
        ack_nx     = 1'b0;
        case (state)
            IDLE: begin
                // A req still held during the ack cycle must not start a new transfer.
                if (req && !ack) begin
                    addr_nx    = addr;
                    be_n_nx    = ~sel;
                    d_out_nx   = wdata;
                    xfer_we_nx = we;
                    ce_n_nx    = 1'b0;
                    d_oe_nx    = we;
                    cnt_nx     = SETUP_LD;
                    state_nx   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    if (xfer_we) we_n_nx = 1'b0;
                    else         oe_n_nx = 1'b0;
                    cnt_nx   = PULSE_LD;
                    state_nx = PULSE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            PULSE: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else if (wait_s) begin
                    we_n_nx  = 1'b1;
                    oe_n_nx  = 1'b1;
                    if (!xfer_we) rdata_nx = mem_d_in;
                    cnt_nx   = HOLD_LD;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    ce_n_nx  = 1'b1;
                    be_n_nx  = '1;
                    d_oe_nx  = 1'b0;
                    ack_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            xfer_we   <= 1'b0;
            mem_addr  <= '0;
            mem_be_n  <= '1;
            mem_d_out <= '0;
            rdata     <= '0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_d_oe  <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            xfer_we   <= xfer_we_nx;
            mem_addr  <= addr_nx;
            mem_be_n  <= be_n_nx;
            mem_d_out <= d_out_nx;
            rdata     <= rdata_nx;
            mem_ce_n  <= ce_n_nx;
            mem_oe_n  <= oe_n_nx;
            mem_we_n  <= we_n_nx;
            mem_d_oe  <= d_oe_nx;
            ack       <= ack_nx;
            busy      <= (state_nx != IDLE);
        end
    end

endmodule
